// File: rtl/program_loader.sv
// program_loader: framed byte-stream loader for instruction memory.
// Assembles big-endian 16-bit words, verifies XOR checksum, gates CPU reset.
module program_loader #(
  parameter int unsigned MAX_WORDS = 256,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        restart,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_write_enable,
  output logic [15:0] imem_write_address,
  output logic [15:0] imem_write_data,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error,
  output logic [15:0] word_count
);

  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] len_q;
  logic [7:0]  chk_q;
  logic [7:0]  hi_q;
  logic [15:0] wc_q;
  logic        wr_en_q;
  logic [15:0] wr_addr_q;
  logic [15:0] wr_data_q;

  logic        take;
  logic [15:0] len_full;
  logic [15:0] wc_inc;

  assign take     = rx_valid && rx_ready;
  assign len_full = {len_q[15:8], rx_data};
  assign wc_inc   = wc_q + 16'd1;

  assign imem_write_enable  = wr_en_q;
  assign imem_write_address = wr_addr_q;
  assign imem_write_data    = wr_data_q;
  assign word_count         = wc_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: restart wins over any byte on the same edge.
  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = S_IDLE;
    end else if (take) begin
      unique case (state_q)
        S_IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            state_d = S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          state_d = S_LEN_LO;
        end
        S_LEN_LO: begin
          if (len_full > MAX_N) begin
            state_d = S_ERROR;
          end else if (len_full == 16'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA_HI;
          end
        end
        S_DATA_HI: begin
          state_d = S_DATA_LO;
        end
        S_DATA_LO: begin
          if (wc_inc == len_q) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA_HI;
          end
        end
        S_CHECK: begin
          if (rx_data == chk_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERROR;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Status outputs decoded from the current state.
  always_comb begin
    rx_ready   = 1'b0;
    cpu_hold   = 1'b1;
    load_done  = 1'b0;
    load_error = 1'b0;
    unique case (state_q)
      S_DONE: begin
        cpu_hold  = 1'b0;
        load_done = 1'b1;
      end
      S_ERROR: begin
        load_error = 1'b1;
      end
      default: begin
        rx_ready = 1'b1;
      end
    endcase
  end

  // Datapath: length, checksum, word assembly and the write strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q     <= '0;
      chk_q     <= '0;
      hi_q      <= '0;
      wc_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      if (restart) begin
        wc_q  <= '0;
        chk_q <= '0;
      end else if (take) begin
        unique case (state_q)
          S_IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              wc_q  <= '0;
              chk_q <= '0;
            end
          end
          S_LEN_HI: begin
            len_q[15:8] <= rx_data;
          end
          S_LEN_LO: begin
            len_q[7:0] <= rx_data;
          end
          S_DATA_HI: begin
            hi_q  <= rx_data;
            chk_q <= chk_q ^ rx_data;
          end
          S_DATA_LO: begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= wc_q;
            wr_data_q <= {hi_q, rx_data};
            chk_q     <= chk_q ^ rx_data;
            wc_q      <= wc_inc;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: table vectors, hand sequences and random frames
// checked against a frame-level reference model.
module tb_program_loader;

  localparam int MAXW = 256;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk;
  logic        reset;
  logic        restart;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_write_enable;
  logic [15:0] imem_write_address;
  logic [15:0] imem_write_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;
  logic [15:0] word_count;

  program_loader #(.MAX_WORDS(MAXW), .SYNC_BYTE(SYNC)) dut (
    .clk(clk),
    .reset(reset),
    .restart(restart),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .rx_ready(rx_ready),
    .imem_write_enable(imem_write_enable),
    .imem_write_address(imem_write_address),
    .imem_write_data(imem_write_data),
    .cpu_hold(cpu_hold),
    .load_done(load_done),
    .load_error(load_error),
    .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] bytes;
    int           n;
    int           gap;
    logic         done;
    logic         err;
    logic [15:0]  wc;
    int           nwr;
    logic [31:0]  w0;
    logic [31:0]  w1;
  } vec_t;

  vec_t        vt[5];
  logic [7:0]  stim_q[$];
  logic [31:0] wr_q[$];
  logic [31:0] exp_wr[$];
  logic        exp_done;
  logic        exp_err;
  logic [15:0] exp_wc;
  int          exp_used;
  int          xfers;
  int          errors = 0;
  int          checks = 0;

  // Write monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_write_enable)
      wr_q.push_back({imem_write_address, imem_write_data});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time exceeded, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer one byte; returns at the negedge after it is taken.
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) begin
      chk("send timeout", 32'(rx_ready), 32'd1);
    end else begin
      xfers++;
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    wr_q.delete();
    xfers = 0;
  endtask

  // gap: 0 back-to-back, 1 every other cycle, 2 random idle cycles.
  task automatic run_stream(input int gap);
    for (int i = 0; i < stim_q.size(); i++) begin
      int g;
      g = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (g) @(negedge clk);
      send_byte(stim_q[i]);
    end
  endtask

  // Reference model: parse the frame from the byte stream directly.
  task automatic model();
    int i;
    int n;
    logic [7:0] x;
    exp_wr.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_wc   = 16'd0;
    i = 0;
    while (i < stim_q.size() && stim_q[i] != SYNC) i++;
    i++;
    n = int'({stim_q[i], stim_q[i+1]});
    i += 2;
    if (n > MAXW) begin
      exp_err  = 1'b1;
      exp_used = i;
      return;
    end
    x = 8'h00;
    for (int w = 0; w < n; w++) begin
      exp_wr.push_back({16'(w), stim_q[i], stim_q[i+1]});
      x = x ^ stim_q[i] ^ stim_q[i+1];
      i += 2;
    end
    exp_wc = 16'(n);
    if (stim_q[i] == x) exp_done = 1'b1;
    else exp_err = 1'b1;
    exp_used = i + 1;
  endtask

  task automatic compare_outcome(input string tag);
    chk({tag, " load_done"}, 32'(load_done), 32'(exp_done));
    chk({tag, " load_error"}, 32'(load_error), 32'(exp_err));
    chk({tag, " cpu_hold"}, 32'(cpu_hold), 32'(!exp_done));
    chk({tag, " rx_ready"}, 32'(rx_ready), 32'd0);
    chk({tag, " word_count"}, 32'(word_count), 32'(exp_wc));
    chk({tag, " transfers"}, xfers, exp_used);
    chk({tag, " nwrites"}, wr_q.size(), exp_wr.size());
    for (int k = 0; k < exp_wr.size() && k < wr_q.size(); k++)
      chk($sformatf("%s write%0d", tag, k), wr_q[k], exp_wr[k]);
  endtask

  initial begin
    vt[0] = '{{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40,
               64'h0}, 8, 0, 1'b1, 1'b0, 16'd2, 2,
              32'h0000_1234, 32'h0001_ABCD};
    vt[1] = '{{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41,
               64'h0}, 8, 0, 1'b0, 1'b1, 16'd2, 2,
              32'h0000_1234, 32'h0001_ABCD};
    vt[2] = '{{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00, 80'h0},
              6, 0, 1'b1, 1'b0, 16'd0, 0, 32'h0, 32'h0};
    vt[3] = '{{8'hA5, 8'h01, 8'h01, 104'h0},
              3, 0, 1'b0, 1'b1, 16'd0, 0, 32'h0, 32'h0};
    vt[4] = '{{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40,
               64'h0}, 8, 1, 1'b1, 1'b0, 16'd2, 2,
              32'h0000_1234, 32'h0001_ABCD};

    reset    = 1'b0;
    restart  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    xfers    = 0;
    #3;
    chk("rst rx_ready", 32'(rx_ready), 32'd1);
    chk("rst we", 32'(imem_write_enable), 32'd0);
    chk("rst addr", 32'(imem_write_address), 32'd0);
    chk("rst data", 32'(imem_write_data), 32'd0);
    chk("rst hold", 32'(cpu_hold), 32'd1);
    chk("rst done", 32'(load_done), 32'd0);
    chk("rst err", 32'(load_error), 32'd0);
    chk("rst wc", 32'(word_count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Table vectors.
    for (int v = 0; v < 5; v++) begin
      pulse_restart();
      stim_q.delete();
      for (int i = 0; i < vt[v].n; i++)
        stim_q.push_back(vt[v].bytes[127-8*i -: 8]);
      exp_done = vt[v].done;
      exp_err  = vt[v].err;
      exp_wc   = vt[v].wc;
      exp_used = vt[v].n;
      exp_wr.delete();
      if (vt[v].nwr > 0) exp_wr.push_back(vt[v].w0);
      if (vt[v].nwr > 1) exp_wr.push_back(vt[v].w1);
      run_stream(vt[v].gap);
      @(negedge clk);
      compare_outcome($sformatf("vec%0d", v));
    end

    // Write latency: strobe exactly one cycle after each low byte.
    pulse_restart();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h12);
    chk("lat we0 early", 32'(imem_write_enable), 32'd0);
    send_byte(8'h34);
    chk("lat we0", 32'(imem_write_enable), 32'd1);
    chk("lat addr0", 32'(imem_write_address), 32'h0);
    chk("lat data0", 32'(imem_write_data), 32'h1234);
    chk("lat wc1", 32'(word_count), 32'd1);
    send_byte(8'hAB);
    chk("lat we gap", 32'(imem_write_enable), 32'd0);
    send_byte(8'hCD);
    chk("lat we1", 32'(imem_write_enable), 32'd1);
    chk("lat addr1", 32'(imem_write_address), 32'h1);
    chk("lat data1", 32'(imem_write_data), 32'hABCD);
    send_byte(8'h40);
    chk("lat we off", 32'(imem_write_enable), 32'd0);
    chk("lat done", 32'(load_done), 32'd1);

    // Restart pulse mid-frame, then a full frame.
    pulse_restart();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h12);
    pulse_restart();
    chk("rs idle ready", 32'(rx_ready), 32'd1);
    chk("rs wc", 32'(word_count), 32'd0);
    stim_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    model();
    run_stream(0);
    @(negedge clk);
    compare_outcome("restart_mid");

    // Restart on the same edge as a completing low byte.
    pulse_restart();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h12);
    rx_valid = 1'b1;
    rx_data  = 8'h34;
    restart  = 1'b1;
    @(negedge clk);
    restart  = 1'b0;
    rx_valid = 1'b0;
    chk("rs_coll we", 32'(imem_write_enable), 32'd0);
    chk("rs_coll wc", 32'(word_count), 32'd0);
    chk("rs_coll ready", 32'(rx_ready), 32'd1);
    @(negedge clk);
    chk("rs_coll nwr", wr_q.size(), 0);

    // Async reset mid-frame, with a low byte offered.
    pulse_restart();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h12);
    rx_valid = 1'b1;
    rx_data  = 8'h34;
    #2;
    reset = 1'b0;
    #1;
    chk("arst wc", 32'(word_count), 32'd0);
    chk("arst data", 32'(imem_write_data), 32'd0);
    chk("arst hold", 32'(cpu_hold), 32'd1);
    @(negedge clk);
    chk("arst we", 32'(imem_write_enable), 32'd0);
    chk("arst nwr", wr_q.size(), 0);
    rx_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    // Random frames against the model.
    for (int k = 0; k < 40; k++) begin
      int pre;
      int n;
      logic [7:0] x;
      logic [7:0] b;
      stim_q.delete();
      pre = $urandom_range(0, 3);
      for (int i = 0; i < pre; i++) begin
        b = 8'($urandom_range(0, 255));
        if (b == SYNC) b = 8'h00;
        stim_q.push_back(b);
      end
      stim_q.push_back(SYNC);
      if ($urandom_range(0, 9) == 0) n = $urandom_range(MAXW + 1, 65535);
      else n = $urandom_range(0, 8);
      stim_q.push_back(8'(n >> 8));
      stim_q.push_back(8'(n));
      if (n <= MAXW) begin
        x = 8'h00;
        for (int i = 0; i < 2 * n; i++) begin
          b = 8'($urandom_range(0, 255));
          x = x ^ b;
          stim_q.push_back(b);
        end
        if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
        stim_q.push_back(x);
      end
      model();
      pulse_restart();
      run_stream(2);
      @(negedge clk);
      compare_outcome($sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
